// File: rtl/io_out_fifo.sv
// rtl/io_out_fifo.sv - output-port FIFO and per-port mirror registers behind the FP core
//
// Purpose:
//   Buffers every OUT write from the floating-point core ({addr_out, data_out})
//   in a small first-word-fall-through FIFO drained by an external consumer
//   over a valid/ready handshake. In parallel, each write updates a mirror
//   register holding the last value written to that output address.
//   A sticky flag records words dropped because the FIFO was full.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous reset, active-high
//   out_en    in   core write strobe, one cycle per OUT instruction
//   addr_out  in   core output address (AW bits)
//   data_out  in   core output word (W bits, passed through bit-exact)
//   m_valid   out  FIFO head valid
//   m_ready   in   consumer accepts the head this cycle
//   m_addr    out  head address
//   m_data    out  head data
//   port_regs out  mirror registers, port k at [k*W +: W]
//   count     out  FIFO occupancy, 0..DEPTH
//   full      out  count == DEPTH
//   ovf       out  sticky overflow flag
//   ovf_clr   in   clears ovf (a coincident overflow wins)

module io_out_fifo #(
  parameter int NBMANT  = 16,
  parameter int NBEXPO  = 6,
  parameter int NUIOOU  = 8,
  parameter int FDEPTHW = 2,
  localparam int W      = NBMANT + NBEXPO + 1,
  localparam int AW     = (NUIOOU > 1) ? $clog2(NUIOOU) : 1,
  localparam int DEPTH  = 2 ** FDEPTHW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  out_en,
  input  logic [AW-1:0]         addr_out,
  input  logic [W-1:0]          data_out,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [AW-1:0]         m_addr,
  output logic [W-1:0]          m_data,
  output logic [NUIOOU*W-1:0]   port_regs,
  output logic [FDEPTHW:0]      count,
  output logic                  full,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam logic [FDEPTHW:0] DEPTH_C = (FDEPTHW+1)'(DEPTH);

  // FIFO storage: {addr, data} per entry. Not reset; occupancy alone decides
  // which entries are meaningful.
  logic [AW+W-1:0]    mem_q [DEPTH];

  // Pointers are exactly FDEPTHW bits so they wrap modulo DEPTH for free.
  logic [FDEPTHW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FDEPTHW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FDEPTHW:0]   count_q,  count_d;
  logic               ovf_q,    ovf_d;
  logic [W-1:0]       port_q [NUIOOU];

  logic push;
  logic pop;
  logic ovf_set;
  logic mirror_hit;

  // ---------------------------------------------------------------------
  // Handshake and status
  // ---------------------------------------------------------------------
  assign m_valid = (count_q != '0);
  assign full    = (count_q == DEPTH_C);
  assign count   = count_q;
  assign ovf     = ovf_q;

  assign pop     = m_valid & m_ready;
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push    = out_en & (~full | pop);
  assign ovf_set = out_en & full & ~pop;

  // Head is read straight from storage (fall-through); it only moves on pop,
  // which keeps m_addr/m_data stable while the consumer stalls.
  assign {m_addr, m_data} = mem_q[rd_ptr_q];

  // Out-of-range addresses still go into the FIFO but touch no mirror.
  assign mirror_hit = out_en & (int'(addr_out) < NUIOOU);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Set has priority over clear so a drop is never lost.
    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {addr_out, data_out};
  end

  // Mirror registers update on every write, including dropped FIFO words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUIOOU; k++) port_q[k] <= '0;
    end else if (mirror_hit) begin
      port_q[addr_out] <= data_out;
    end
  end

  for (genvar k = 0; k < NUIOOU; k++) begin : g_port
    assign port_regs[k*W +: W] = port_q[k];
  end

endmodule

// File: tb/tb_io_out_fifo.sv
// tb/tb_io_out_fifo.sv - scoreboard bench for io_out_fifo

module tb_io_out_fifo;

  localparam int NBMANT  = 16;
  localparam int NBEXPO  = 6;
  localparam int NUIOOU  = 8;
  localparam int FDEPTHW = 2;
  localparam int W       = NBMANT + NBEXPO + 1;
  localparam int AW      = 3;
  localparam int DEPTH   = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                out_en;
  logic [AW-1:0]       addr_out;
  logic [W-1:0]        data_out;
  logic                m_valid;
  logic                m_ready;
  logic [AW-1:0]       m_addr;
  logic [W-1:0]        m_data;
  logic [NUIOOU*W-1:0] port_regs;
  logic [FDEPTHW:0]    count;
  logic                full;
  logic                ovf;
  logic                ovf_clr;

  io_out_fifo #(
    .NBMANT(NBMANT), .NBEXPO(NBEXPO), .NUIOOU(NUIOOU), .FDEPTHW(FDEPTHW)
  ) dut (
    .clk(clk), .rst(rst), .out_en(out_en), .addr_out(addr_out),
    .data_out(data_out), .m_valid(m_valid), .m_ready(m_ready),
    .m_addr(m_addr), .m_data(m_data), .port_regs(port_regs),
    .count(count), .full(full), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  logic [AW+W-1:0] exp_q [$];
  logic [W-1:0]    exp_port [NUIOOU];
  logic            exp_ovf;
  int              n_pass  = 0;
  int              n_total = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  task automatic check_ports();
    for (int k = 0; k < NUIOOU; k++)
      check_eq($sformatf("port%0d", k), 64'(port_regs[k*W +: W]), 64'(exp_port[k]));
  endtask

  // Checks outputs at the falling edge against the model, then advances the
  // model by the handshake that the next rising edge will perform.
  task automatic cycle();
    logic [AW+W-1:0] head;
    bit pop_e, push_e;
    @(negedge clk);
    check_eq("count",   64'(count),   64'(exp_q.size()));
    check_eq("m_valid", 64'(m_valid), 64'(exp_q.size() != 0));
    check_eq("full",    64'(full),    64'(exp_q.size() == DEPTH));
    check_eq("ovf",     64'(ovf),     64'(exp_ovf));
    check_ports();
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      check_eq("m_addr", 64'(m_addr), 64'(head[AW+W-1:W]));
      check_eq("m_data", 64'(m_data), 64'(head[W-1:0]));
    end
    pop_e  = (exp_q.size() != 0) && m_ready;
    push_e = out_en && ((exp_q.size() < DEPTH) || pop_e);
    if (pop_e)  head = exp_q.pop_front();
    if (push_e) exp_q.push_back({addr_out, data_out});
    if (out_en && !push_e) exp_ovf = 1'b1;
    else if (ovf_clr)      exp_ovf = 1'b0;
    if (out_en && int'(addr_out) < NUIOOU) exp_port[addr_out] = data_out;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [AW-1:0] a, input logic [W-1:0] d,
                       input logic rdy, input logic clr);
    out_en = en; addr_out = a; data_out = d; m_ready = rdy; ovf_clr = clr;
    cycle();
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && exp_q.size() != 0; i++) drive(1'b0, '0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check_eq("drain_empty", 64'(count), 64'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_valid"}, 64'(m_valid), 64'd0);
    check_eq({tag, "_count"}, 64'(count),   64'd0);
    check_eq({tag, "_full"},  64'(full),    64'd0);
    check_eq({tag, "_ovf"},   64'(ovf),     64'd0);
    check_ports();
  endtask

  initial begin
    rst = 1'b1; out_en = 1'b0; addr_out = '0; data_out = '0;
    m_ready = 1'b0; ovf_clr = 1'b0; exp_ovf = 1'b0;
    for (int k = 0; k < NUIOOU; k++) exp_port[k] = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("rst0");
    rst = 1'b0;

    // 1: single write, visible the next cycle
    drive(1'b1, 3'd3, 23'h1A2B3C, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check_eq("s1_port3", 64'(port_regs[3*W +: W]), 64'h1A2B3C);
    drain();

    // 2: fill, overflow drop still updates mirror, drain in order
    for (int i = 0; i < 4; i++) drive(1'b1, AW'(i), W'(23'h000100 + i), 1'b0, 1'b0);
    drive(1'b1, 3'd5, 23'd7, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check_eq("s2_ovf",   64'(ovf),  64'd1);
    check_eq("s2_full",  64'(full), 64'd1);
    check_eq("s2_port5", 64'(port_regs[5*W +: W]), 64'd7);
    drain();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b0);

    // 3: full with simultaneous pop and push
    for (int i = 0; i < 4; i++) drive(1'b1, AW'(i + 2), W'(23'h020000 + i), 1'b0, 1'b0);
    drive(1'b1, 3'd6, 23'h7FFFFF, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check_eq("s3_count", 64'(count), 64'd4);
    check_eq("s3_ovf",   64'(ovf),   64'd0);
    drain();

    // 4: streaming through, pointers wrap several times
    for (int i = 0; i < 20; i++) drive(1'b1, AW'(i), W'(23'h040000 + i), 1'b1, 1'b0);
    drain();

    // 5: set beats clear, then clear alone
    for (int i = 0; i < 5; i++) drive(1'b1, AW'(7 - i), W'(23'h050000 + i), 1'b0, 1'b0);
    drive(1'b1, 3'd1, 23'h055555, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check_eq("s5_ovf_clr", 64'(ovf), 64'd0);
    drain();

    // 6: async reset with three entries pending and ovf set
    for (int i = 0; i < 5; i++) drive(1'b1, AW'(i), W'(23'h060000 + i), 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    check_eq("s6_pre_count", 64'(count), 64'd3);
    #1 rst = 1'b1;
    #1;
    exp_q.delete();
    exp_ovf = 1'b0;
    for (int k = 0; k < NUIOOU; k++) exp_port[k] = '0;
    check_reset_state("rst6");
    rst = 1'b0;
    drive(1'b1, 3'd3, 23'h1A2B3C, 1'b0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    drain();

    // random traffic against the model
    for (int i = 0; i < 200; i++)
      drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, NUIOOU - 1)),
            W'($urandom_range(0, 32'h7FFFFF)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 7) == 0));
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
